serial_tx_sequencer: RTL and testbench
======================================

# serial_tx_sequencer

Controller that sequences a parallel-load, MSB-first shift register to serialise words onto a single-bit line. It accepts one word at a time over a valid/ready handshake, then drives exactly WIDTH bit-cycles with a frame-active qualifier. It pulses done when the frame ends and enforces a configurable idle gap before the next word. It sits between a word producer (counter, FIFO, testbench) and any serial consumer in the SHIFT REGISTERS family.

## Interface
- WIDTH, 8, bits per frame; legal range 2..32.
- GAP, 2, idle cycles inserted after each frame; legal range 0..15.

- clk  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  sequencer can accept a word this cycle
- in_data  input  WIDTH  word to serialise, bit WIDTH-1 sent first
- serial_out  output  1  serial data, registered
- frame_active  output  1  high exactly during the WIDTH bit-cycles of a frame
- done  output  1  one-cycle pulse after the last bit of a frame

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1, frame_active=0, serial_out=0.
  - If in_valid is high at a rising edge, capture in_data into the shift register, clear bit_cnt and enter SHIFT.
  - If in_valid is low, stay in IDLE.
- SHIFT:
  - in_ready=0, frame_active=1, serial_out = shift register MSB.
  - On each edge, shift left by one (zero fill) and increment bit_cnt.
  - When bit_cnt==WIDTH-1 at an edge, leave SHIFT: go to GAP if GAP>0, otherwise go to IDLE.
- GAP:
  - in_ready=0, frame_active=0, serial_out=0.
  - gap_cnt counts GAP cycles, then the state returns to IDLE.
- done:
  - Registered. It is high for exactly one cycle, the cycle immediately after the last SHIFT cycle.
  - That cycle is the first GAP cycle, or the first IDLE cycle when GAP=0.
- in_data is sampled only on an accepted handshake. Changes to in_data during SHIFT have no effect.
- in_valid held high continuously produces back-to-back frames separated by exactly GAP idle cycles, plus the one IDLE acceptance cycle.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - gap_cnt is 4 bits.
  - Neither counter wraps in normal operation; each is cleared when its state is entered.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=1, serial_out=0, frame_active=0, done=0.
  - Shift register, bit_cnt and gap_cnt all 0.
- Latency: handshake accepted at edge E0 means serial_out = in_data[WIDTH-1] is visible from E0 to E1.
- Bit k (k = 0..WIDTH-1) is valid between edges E0+k and E0+k+1.
- The frame occupies WIDTH cycles.
- done is high from edge E0+WIDTH to edge E0+WIDTH+1.
- in_ready returns high at edge E0+WIDTH+GAP.
- Frame period with in_valid held high is WIDTH+GAP+1 cycles.
- Reset mid-frame or mid-gap:
  - The next edge forces IDLE and all reset values.
  - The partial frame is dropped and no done pulse is issued.
  - A handshake in the same cycle as reset is ignored.
- in_valid high while in_ready is low is not an error. The word is held by the producer and accepted on the next IDLE cycle.

## Structure
- Shared include file tx_seq_defs.vh holds:
  - State encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_GAP=2'd2.
  - Default WIDTH/GAP constants.
- Sub-module piso_shift_core (parameter WIDTH; ports clk, reset, load, shift_en, din[WIDTH], msb).
  - Holds the shift register only.
  - load has priority over shift_en.
- Top-level serial_tx_sequencer contains the FSM, both counters, the done register and the output decode.

## Test plan
- Reset: hold reset for 2 cycles.
  - Required: in_ready=1, serial_out=0, frame_active=0, done=0.
- Single frame, WIDTH=4, GAP=2, in_data=4'b1011.
  - Required: serial_out = 1,0,1,1 across 4 cycles with frame_active=1.
  - Required: done pulses on the 5th cycle.
  - Required: in_ready=0 for 6 cycles in total, then returns to 1.
- Back-to-back, WIDTH=8, GAP=0, in_valid held high with words 8'hA5 then 8'h3C.
  - Required: bit streams 10100101 then 00111100.
  - Required: exactly 1 idle cycle between the two frames.
  - Required: two done pulses, 9 cycles apart.
- Stall: in_valid asserted during SHIFT, with in_data changed mid-frame.
  - Required: the current frame bits are unchanged.
  - Required: the new word is accepted on the first IDLE cycle.
- Reset mid-frame: assert reset after bit 2 of 8'hFF.
  - Required: next cycle serial_out=0, frame_active=0, no done pulse, in_ready=1.
- Boundary, WIDTH=2, GAP=15, data 2'b10.
  - Required: 2 bit-cycles, then done, then in_ready low for exactly 15 more cycles.

Source files
------------

// File: rtl/serial_tx_sequencer_pkg.sv
// ============================================================================
// Module : serial_tx_sequencer_pkg
// Brief  : Shared state encodings and default parameters for the serial
//          transmit sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_tx_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 2;
    localparam int GAP_CNT_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_shift_core.sv
// ============================================================================
// Module : piso_shift_core
// Brief  : Parallel-load, MSB-first shift register; load wins over shift.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module piso_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift_en) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb = sreg_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/serial_tx_sequencer.sv
// ============================================================================
// Module : serial_tx_sequencer
// Brief  : Accepts one word per handshake, emits WIDTH serial bit-cycles,
//          pulses done, then holds off for GAP idle cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_tx_sequencer
    import serial_tx_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             frame_active,
    output logic             done
);

    localparam int                   CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 done_q, done_d;
    logic                 load;
    logic                 shift_en;
    logic                 msb;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                // The last bit-cycle holds bit_cnt so it never wraps.
                if (bit_cnt_q == BIT_LAST) begin
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    piso_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .din      (in_data),
        .msb      (msb)
    );

    assign in_ready     = (state_q == S_IDLE);
    assign frame_active = (state_q == S_SHIFT);
    assign serial_out   = frame_active & msb;
    assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_sequencer.sv
// ============================================================================
// Module : tb_serial_tx_sequencer
// Brief  : Directed bench driving three sequencer configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_tx_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // WIDTH=4, GAP=2
    logic       v4, r4, so4, fa4, dn4;
    logic [3:0] d4;
    // WIDTH=8, GAP=0
    logic       v8, r8, so8, fa8, dn8;
    logic [7:0] d8;
    // WIDTH=2, GAP=15
    logic       v2, r2, so2, fa2, dn2;
    logic [1:0] d2;

    always #5 clk = ~clk;

    serial_tx_sequencer #(.WIDTH(4), .GAP(2)) u4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .in_data(d4),
        .serial_out(so4), .frame_active(fa4), .done(dn4)
    );
    serial_tx_sequencer #(.WIDTH(8), .GAP(0)) u8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8), .in_data(d8),
        .serial_out(so8), .frame_active(fa8), .done(dn8)
    );
    serial_tx_sequencer #(.WIDTH(2), .GAP(15)) u2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(r2), .in_data(d2),
        .serial_out(so2), .frame_active(fa2), .done(dn2)
    );

    task automatic test_reset();
        reset = 1'b1;
        v4 = 1'b0; v8 = 1'b0; v2 = 1'b0;
        d4 = '0; d8 = '0; d2 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({r4, so4, fa4, dn4} !== 4'b1000) begin
            errors++; $display("FAIL reset_w4: got %b expected 1000", {r4, so4, fa4, dn4});
        end
        checks++;
        if ({r8, so8, fa8, dn8} !== 4'b1000) begin
            errors++; $display("FAIL reset_w8: got %b expected 1000", {r8, so8, fa8, dn8});
        end
        checks++;
        if ({r2, so2, fa2, dn2} !== 4'b1000) begin
            errors++; $display("FAIL reset_w2: got %b expected 1000", {r2, so2, fa2, dn2});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [3:0] w;
        int         ready_low;
        w = 4'b1011;
        ready_low = 0;
        v4 = 1'b1; d4 = w;
        @(negedge clk);
        v4 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            logic exp_so, exp_fa, exp_dn, exp_rdy;
            exp_so  = (k < 4) ? w[3-k] : 1'b0;
            exp_fa  = (k < 4);
            exp_dn  = (k == 4);
            exp_rdy = (k == 6);
            if (!r4) ready_low++;
            checks++;
            if ({so4, fa4, dn4, r4} !== {exp_so, exp_fa, exp_dn, exp_rdy}) begin
                errors++;
                $display("FAIL single_frame k=%0d: got so/fa/done/rdy=%b expected %b",
                         k, {so4, fa4, dn4, r4}, {exp_so, exp_fa, exp_dn, exp_rdy});
            end
            @(negedge clk);
        end
        checks++;
        if (ready_low != 6) begin
            errors++; $display("FAIL single_ready_low: got %0d cycles expected 6", ready_low);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1, w2;
        int         done_cnt, first_done, second_done;
        w1 = 8'hA5; w2 = 8'h3C;
        done_cnt = 0; first_done = -1; second_done = -1;
        v8 = 1'b1; d8 = w1;
        @(negedge clk);
        d8 = w2;
        for (int k = 0; k < 19; k++) begin
            logic exp_so, exp_fa, exp_rdy;
            exp_so  = (k < 8) ? w1[7-k] : ((k >= 9 && k < 17) ? w2[16-k] : 1'b0);
            exp_fa  = (k < 8) || (k >= 9 && k < 17);
            exp_rdy = (k == 8) || (k >= 17);
            if (dn8) begin
                done_cnt++;
                if (first_done < 0) first_done = k; else second_done = k;
            end
            checks++;
            if ({so8, fa8, r8} !== {exp_so, exp_fa, exp_rdy}) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got so/fa/rdy=%b expected %b",
                         k, {so8, fa8, r8}, {exp_so, exp_fa, exp_rdy});
            end
            if (k == 9) v8 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 2 || first_done != 8 || second_done != 17) begin
            errors++;
            $display("FAIL b2b_done: got count=%0d at %0d,%0d expected count=2 at 8,17",
                     done_cnt, first_done, second_done);
        end
    endtask

    task automatic test_stall();
        logic [3:0] w1, w2;
        w1 = 4'b1001; w2 = 4'b0110;
        v4 = 1'b1; d4 = w1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            logic exp_so, exp_fa, exp_rdy;
            if (k == 1) d4 = w2;
            exp_so  = (k < 4) ? w1[3-k] : ((k >= 7) ? w2[10-k] : 1'b0);
            exp_fa  = (k < 4) || (k >= 7);
            exp_rdy = (k == 6);
            checks++;
            if ({so4, fa4, r4} !== {exp_so, exp_fa, exp_rdy}) begin
                errors++;
                $display("FAIL stall k=%0d: got so/fa/rdy=%b expected %b",
                         k, {so4, fa4, r4}, {exp_so, exp_fa, exp_rdy});
            end
            if (k == 7) v4 = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (r4 !== 1'b1) begin
            errors++; $display("FAIL stall_drain: got ready=%b expected 1", r4);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        done_seen = 0;
        v8 = 1'b1; d8 = 8'hFF;
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({so8, fa8} !== 2'b11) begin
            errors++; $display("FAIL mid_bit2: got so/fa=%b expected 11", {so8, fa8});
        end
        reset = 1'b1;
        v8 = 1'b1;
        @(negedge clk);
        checks++;
        if ({so8, fa8, dn8, r8} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset: got so/fa/done/rdy=%b expected 0001", {so8, fa8, dn8, r8});
        end
        @(negedge clk);
        checks++;
        if ({fa8, r8} !== 2'b01) begin
            errors++; $display("FAIL reset_handshake: got fa/rdy=%b expected 01", {fa8, r8});
        end
        reset = 1'b0;
        v8 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (dn8) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen != 0 || r8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_done: got done=%0d rdy=%b expected 0 and 1", done_seen, r8);
        end
    endtask

    task automatic test_boundary();
        int ready_low;
        ready_low = 0;
        v2 = 1'b1; d2 = 2'b10;
        @(negedge clk);
        v2 = 1'b0;
        checks++;
        if ({so2, fa2, r2} !== 3'b110) begin
            errors++; $display("FAIL bnd_bit0: got so/fa/rdy=%b expected 110", {so2, fa2, r2});
        end
        @(negedge clk);
        checks++;
        if ({so2, fa2, r2} !== 3'b010) begin
            errors++; $display("FAIL bnd_bit1: got so/fa/rdy=%b expected 010", {so2, fa2, r2});
        end
        @(negedge clk);
        checks++;
        if ({dn2, fa2} !== 2'b10) begin
            errors++; $display("FAIL bnd_done: got done/fa=%b expected 10", {dn2, fa2});
        end
        for (int k = 0; k < 16; k++) begin
            if (!r2) ready_low++;
            @(negedge clk);
        end
        checks++;
        if (ready_low != 15 || r2 !== 1'b1) begin
            errors++;
            $display("FAIL bnd_gap: got low=%0d rdy=%b expected 15 and 1", ready_low, r2);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
